sram147456x6_arb: RTL
=====================

Name: sram147456x6_arb

Overview:
- Two-requester access controller for the 147456x6 soft-bit buffer (six-bit soft bits, single-port, registered read).
- Shares the buffer between a writer (demapper/deinterleaver fill side) and a reader (LDPC decoder fetch side).
- Registers all memory commands and returns read data with fixed latency.
- Enforces the legal address range (0..147455) and bounds reader starvation when the writer is streaming.

Parameters:
- A_WID, 18, address width.
- D_WID, 6, soft-bit data width.
- MEM_DEPTH, 147456, number of valid addresses; any address >= MEM_DEPTH is illegal.
- STARVE_MAX, 4, maximum consecutive writer grants while the reader is waiting; must be >= 1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active high.
- wr_req  in  1  write request; held until acked.
- wr_addr  in  A_WID  write address.
- wr_data  in  D_WID  write data.
- wr_ack  out  1  combinational; high in the grant cycle; request consumed this cycle.
- rd_req  in  1  read request; held until acked.
- rd_addr  in  A_WID  read address.
- rd_ack  out  1  combinational; high in the grant cycle.
- rd_valid  out  1  registered; one-cycle pulse per granted read.
- rd_data  out  D_WID  registered read data; qualified by rd_valid.
- addr_err  out  1  registered; one-cycle pulse when a granted request has an illegal address.
- mem_ce  out  1  registered buffer chip enable (active high).
- mem_we  out  1  registered buffer write enable (active high).
- mem_a  out  A_WID  registered buffer address.
- mem_d  out  D_WID  registered buffer write data.
- mem_q  in  D_WID  buffer read data; valid the cycle after the buffer samples a read.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - mem_ce, mem_we, rd_valid and addr_err are cleared to 0.
  - mem_a, mem_d and rd_data are cleared to 0.
  - starve_cnt is cleared to 0.
  - The read-tracking pipeline (rd_p1, rd_p2 valid bits and their error flags) is cleared. In-flight reads are dropped and produce no rd_valid.
  - wr_ack and rd_ack are 0 while RST=1.
- Grant (combinational, evaluated each cycle, at most one grant per cycle):
  - Only wr_req set: grant the writer.
  - Only rd_req set: grant the reader.
  - Both set: grant the reader if starve_cnt == STARVE_MAX, otherwise grant the writer.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments on a writer grant while rd_req=1.
  - Clears on a reader grant, or in any cycle with rd_req=0.
  - Never exceeds STARVE_MAX.
- Command register (cycle t+1 after a grant in cycle t):
  - Legal address: mem_ce=1; mem_we=1 for a write, 0 for a read; mem_a = granted address; mem_d = wr_data for a write, 0 for a read.
  - Illegal address: mem_ce=0 and mem_we=0. addr_err=1 in t+1.
  - No grant: mem_ce=0 and mem_we=0. mem_a and mem_d hold their previous values.
- Read return:
  - A read granted in cycle t sets rd_p1 in t+1 and rd_p2 in t+2.
  - mem_q is sampled at the end of t+2; rd_valid=1 with rd_data=mem_q in cycle t+3. Total latency is 3 cycles.
  - An illegal-address read still produces rd_valid in t+3, with rd_data=0.
  - rd_data holds its value when rd_valid=0.
- Throughput and ordering:
  - One access per cycle. Back-to-back reads return in order, one per cycle.
  - A write followed by a read to the same address on the next grant returns the new data. The buffer is written at the end of t+1 and read at the end of t+2.
- Address boundaries:
  - 147455 (0x23FFF) is legal.
  - 147456 (0x24000) and 0x3FFFF are illegal.

Optional Feature:
- Macro: SRAM147456X6_ARB_STAT_EN.
- Defined:
  - Adds output ports wr_cnt[31:0], rd_cnt[31:0] and err_cnt[15:0], all registered and cleared by RST.
  - wr_cnt and rd_cnt count granted writes and reads, legal or not.
  - err_cnt counts addr_err pulses.
  - All three saturate at their maximum value.
- Undefined: none of these ports or registers exist. All other behaviour is identical.

Test Plan:
- Reset mid-read: grant a read at 0x00010, assert RST in t+1 -> no rd_valid ever appears; all outputs are 0 the cycle after reset.
- Single write/read: write 0x2A to 0x23FFF, then read 0x23FFF -> mem_ce=1 and mem_we=1 one cycle after the write ack; rd_valid=1 with rd_data=0x2A exactly 3 cycles after rd_ack.
- Illegal address: write to 0x24000, read from 0x3FFFF -> mem_ce stays 0; addr_err pulses in each t+1; the read returns rd_valid with rd_data=0.
- Starvation bound: wr_req and rd_req both held continuously, STARVE_MAX=4 -> grant pattern W,W,W,W,R repeating; the reader is granted every 5th cycle.
- Streaming reads: rd_req held for addresses 0..7 preloaded with 0..7 -> 8 consecutive rd_valid pulses with data 0..7 in order, no gaps.
- STAT build (SRAM147456X6_ARB_STAT_EN defined): 10 writes, 6 reads, 2 illegal -> wr_cnt + rd_cnt = 16, err_cnt = 2; reset clears all three to 0.

Source files
------------

// File: rtl/sram147456x6_arb.sv
// -----------------------------------------------------------------------------
// sram147456x6_arb
//   Two-requester access controller for the 147456x6 soft-bit buffer.
//   The writer (demapper/deinterleaver fill side) and the reader (LDPC decoder
//   fetch side) share a single-port buffer with a registered read. Every
//   buffer command is registered. Read data returns exactly 3 cycles after
//   the read grant. Addresses >= MEM_DEPTH are rejected: no buffer access is
//   issued and addr_err pulses. A streaming writer cannot starve the reader
//   for more than STARVE_MAX consecutive grants.
//
//   Optional statistics: define SRAM147456X6_ARB_STAT_EN to add the wr_cnt,
//   rd_cnt and err_cnt saturating counters. They are not present by default.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   wr_req/addr/data  write request (held until wr_ack)
//   wr_ack          combinational grant to the writer
//   rd_req/addr     read request (held until rd_ack)
//   rd_ack          combinational grant to the reader
//   rd_valid/data   registered read return, 3 cycles after rd_ack
//   addr_err        registered pulse, one cycle after an illegal-address grant
//   mem_ce/we/a/d   registered buffer command
//   mem_q           buffer read data (valid the cycle after a read is sampled)
//   wr_cnt, rd_cnt, err_cnt  (STAT build only) saturating counters
// -----------------------------------------------------------------------------
module sram147456x6_arb #(
  parameter int A_WID      = 18,
  parameter int D_WID      = 6,
  parameter int MEM_DEPTH  = 147456,
  parameter int STARVE_MAX = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_req,
  input  logic [A_WID-1:0] wr_addr,
  input  logic [D_WID-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  input  logic [A_WID-1:0] rd_addr,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [D_WID-1:0] rd_data,
  output logic             addr_err,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [A_WID-1:0] mem_a,
  output logic [D_WID-1:0] mem_d,
  input  logic [D_WID-1:0] mem_q
`ifdef SRAM147456X6_ARB_STAT_EN
  ,
  output logic [31:0]      wr_cnt,
  output logic [31:0]      rd_cnt,
  output logic [15:0]      err_cnt
`endif
);

  localparam int SC_WID = $clog2(STARVE_MAX + 1);
  localparam logic [SC_WID-1:0] STARVE_TOP = SC_WID'(STARVE_MAX);
  // One extra bit so the depth itself (2**17 + 2**14) is representable.
  localparam logic [A_WID:0] DEPTH_L = (A_WID + 1)'(MEM_DEPTH);

  logic [SC_WID-1:0] starve_cnt_q, starve_cnt_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [A_WID-1:0]  mem_a_q, mem_a_d;
  logic [D_WID-1:0]  mem_d_q, mem_d_d;
  logic              addr_err_q, addr_err_d;
  logic              rd_p1_q, rd_p1_d;
  logic              rd_p1_err_q, rd_p1_err_d;
  logic              rd_p2_q, rd_p2_d;
  logic              rd_p2_err_q, rd_p2_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [D_WID-1:0]  rd_data_q, rd_data_d;

  logic              wr_grant, rd_grant, any_grant, sel_legal;
  logic [A_WID-1:0]  sel_addr;

  // Grant: the reader wins a contested cycle only once the writer has used
  // its full run of STARVE_MAX consecutive grants.
  always_comb begin
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    if (!RST) begin
      if (wr_req && rd_req) begin
        rd_grant = (starve_cnt_q == STARVE_TOP);
        wr_grant = !rd_grant;
      end else begin
        wr_grant = wr_req;
        rd_grant = rd_req;
      end
    end
  end

  assign any_grant = wr_grant | rd_grant;
  assign sel_addr  = rd_grant ? rd_addr : wr_addr;
  assign sel_legal = ({1'b0, sel_addr} < DEPTH_L);

  always_comb begin
    // Starvation counter
    starve_cnt_d = starve_cnt_q;
    if (rd_grant || !rd_req) begin
      starve_cnt_d = '0;
    end else if (wr_grant && (starve_cnt_q != STARVE_TOP)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    // Command register: an illegal grant issues no access and leaves the
    // address/data bus holding its last legal command.
    mem_ce_d   = any_grant & sel_legal;
    mem_we_d   = wr_grant & sel_legal;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    if (any_grant && sel_legal) begin
      mem_a_d = sel_addr;
      mem_d_d = wr_grant ? wr_data : '0;
    end
    addr_err_d = any_grant & ~sel_legal;

    // Read return pipeline: p1 = command cycle, p2 = buffer output cycle.
    rd_p1_d     = rd_grant;
    rd_p1_err_d = rd_grant & ~sel_legal;
    rd_p2_d     = rd_p1_q;
    rd_p2_err_d = rd_p1_err_q;
    rd_valid_d  = rd_p2_q;
    rd_data_d   = rd_data_q;
    if (rd_p2_q) begin
      rd_data_d = rd_p2_err_q ? '0 : mem_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt_q <= '0;
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_a_q      <= '0;
      mem_d_q      <= '0;
      addr_err_q   <= 1'b0;
      rd_p1_q      <= 1'b0;
      rd_p1_err_q  <= 1'b0;
      rd_p2_q      <= 1'b0;
      rd_p2_err_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_a_q      <= mem_a_d;
      mem_d_q      <= mem_d_d;
      addr_err_q   <= addr_err_d;
      rd_p1_q      <= rd_p1_d;
      rd_p1_err_q  <= rd_p1_err_d;
      rd_p2_q      <= rd_p2_d;
      rd_p2_err_q  <= rd_p2_err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign wr_ack   = wr_grant;
  assign rd_ack   = rd_grant;
  assign mem_ce   = mem_ce_q;
  assign mem_we   = mem_we_q;
  assign mem_a    = mem_a_q;
  assign mem_d    = mem_d_q;
  assign addr_err = addr_err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef SRAM147456X6_ARB_STAT_EN
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counters; err_cnt follows the registered addr_err pulse.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (wr_grant && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
    if (rd_grant && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
    if (addr_err_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule
